// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and sizes for the voice step sequencer
package synth_pkg;

    localparam int STEPS    = 8;
    localparam int PERIOD_W = 32;
    localparam int LEN_W    = 16;
    localparam int STEP_W   = $clog2(STEPS);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [LEN_W-1:0]    len;
    } step_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// rtl/seq_pattern_ram.sv - STEPS-entry pattern store, synchronous write, asynchronous read
module seq_pattern_ram
    import synth_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  step_t             wr_data,
    input  logic [STEP_W-1:0] rd_addr,
    output step_t             rd_data
);

    step_t mem_q [STEPS];
    step_t mem_d [STEPS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read returns pre-write contents, so a same-cycle load sees the old entry.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/noise_sequencer.sv
// rtl/noise_sequencer.sv - pattern step sequencer driving a voice's period and gate
module noise_sequencer
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [STEP_W-1:0]   wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [LEN_W-1:0]    wr_len,
    input  logic [31:0]         tick_div,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    output logic [PERIOD_W-1:0] period,
    output logic                gate,
    output logic [STEP_W-1:0]   step,
    output logic                busy,
    output logic                done
);

    seq_state_t          state_q,   state_d;
    logic [STEP_W-1:0]   step_q,    step_d;
    logic [PERIOD_W-1:0] period_q,  period_d;
    logic                gate_q,    gate_d;
    logic                done_q,    done_d;
    logic [31:0]         div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0]    len_cnt_q, len_cnt_d;
    logic [LEN_W-1:0]    cur_len_q, cur_len_d;

    logic [STEP_W-1:0]   rd_addr;
    step_t               rd_data;
    step_t               wr_data;
    logic [31:0]         div_last;
    logic [LEN_W-1:0]    len_last;
    logic                tick;
    logic                expire;
    logic                last_step;

    assign wr_data = '{period: wr_period, len: wr_len};

    seq_pattern_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        div_last  = (tick_div == 32'd0) ? 32'd0 : tick_div - 32'd1;
        len_last  = (cur_len_q == '0) ? '0 : cur_len_q - LEN_W'(1);
        tick      = (state_q == PLAY) && (div_cnt_q == div_last);
        expire    = tick && (len_cnt_q == len_last);
        last_step = (step_q == STEP_W'(STEPS - 1));
        rd_addr   = start ? '0 : step_q + STEP_W'(1);

        state_d   = state_q;
        step_d    = step_q;
        period_d  = period_q;
        gate_d    = gate_q;
        done_d    = 1'b0;
        div_cnt_d = div_cnt_q;
        len_cnt_d = len_cnt_q;
        cur_len_d = cur_len_q;

        if (stop || (state_q == PLAY && expire && last_step && !loop && !start)) begin
            state_d   = IDLE;
            step_d    = '0;
            period_d  = '0;
            gate_d    = 1'b0;
            div_cnt_d = '0;
            len_cnt_d = '0;
            done_d    = !stop;
        end else if (start || (state_q == PLAY && expire)) begin
            // Length is latched at load so a rewrite of the live step cannot stretch it.
            state_d   = PLAY;
            step_d    = rd_addr;
            period_d  = rd_data.period;
            gate_d    = (rd_data.period != '0);
            cur_len_d = rd_data.len;
            div_cnt_d = '0;
            len_cnt_d = '0;
        end else if (state_q == PLAY) begin
            div_cnt_d = tick ? 32'd0 : div_cnt_q + 32'd1;
            if (tick) begin
                len_cnt_d = len_cnt_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            period_q  <= '0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            div_cnt_q <= '0;
            len_cnt_q <= '0;
            cur_len_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            period_q  <= period_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            div_cnt_q <= div_cnt_d;
            len_cnt_q <= len_cnt_d;
            cur_len_q <= cur_len_d;
        end
    end

    assign period = period_q;
    assign gate   = gate_q;
    assign step   = step_q;
    assign busy   = (state_q == PLAY);
    assign done   = done_q;

endmodule
